// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types for the line-granular memory arbiter: FSM states and grant policy.
package rv32i_types;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } arb_state_t;

   typedef enum logic {
      ARB_RR,
      ARB_FIXED
   } arb_mode_t;

endpackage

// File: rtl/mem_arbiter_rr_prio_enc.sv
// Rotating priority encoder: first set request at or after start, wrapping modulo N.
module rr_priority_encoder #(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] start,
   output logic                 found,
   output logic [$clog2(N)-1:0] idx
);

   localparam int unsigned IW = $clog2(N);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [IW-1:0]  off;
   logic [IW:0]    sum;

   // Rotate so bit 0 of rot corresponds to port 'start'.
   assign dbl = {req, req} >> start;
   assign rot = dbl[N-1:0];

   always_comb begin
      found = 1'b0;
      off   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            off   = IW'(k);
         end
      end
   end

   always_comb begin
      sum = {1'b0, start} + {1'b0, off};
      if (sum >= (IW + 1)'(N)) begin
         sum = sum - (IW + 1)'(N);
      end
      idx = sum[IW-1:0];
   end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port cache-line arbiter in front of the single L2 port; one latched transaction at a time.
module mem_arbiter_rr
   import rv32i_types::*;
#(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned LINE_WIDTH = 256,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter arb_mode_t   ARB_MODE   = ARB_RR
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            req_read,
   input  logic [NUM_PORTS-1:0]            req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
   output logic [LINE_WIDTH-1:0]           req_rdata,
   output logic [NUM_PORTS-1:0]            req_resp,
   output logic [ADDR_WIDTH-1:0]           mem_address,
   output logic [LINE_WIDTH-1:0]           mem_wdata,
   output logic                            mem_read,
   output logic                            mem_write,
   input  logic [LINE_WIDTH-1:0]           mem_rdata,
   input  logic                            mem_resp,
   output logic                            grant_valid,
   output logic [$clog2(NUM_PORTS)-1:0]    grant_idx
);

   localparam int unsigned IW = $clog2(NUM_PORTS);

   arb_state_t state_q, state_d;

   logic [IW-1:0]         rr_ptr_q;
   logic [IW-1:0]         grant_idx_q;
   logic [IW-1:0]         ptr_next;
   logic                  mem_read_q, mem_write_q;
   logic [ADDR_WIDTH-1:0] mem_address_q;
   logic [LINE_WIDTH-1:0] mem_wdata_q;

   logic [NUM_PORTS-1:0]  req_any;
   logic [IW-1:0]         enc_start;
   logic                  enc_found;
   logic [IW-1:0]         enc_idx;
   logic                  sel_read, sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [LINE_WIDTH-1:0] sel_wdata;
   logic                  launch, complete;

   assign req_any   = req_read | req_write;
   assign enc_start = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr_q;

   rr_priority_encoder #(
      .N(NUM_PORTS)
   ) u_enc (
      .req  (req_any),
      .start(enc_start),
      .found(enc_found),
      .idx  (enc_idx)
   );

   always_comb begin
      sel_read  = 1'b0;
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (enc_idx == IW'(i)) begin
            sel_read  = req_read[i];
            sel_write = req_write[i];
            sel_addr  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
         end
      end
   end

   assign launch   = (state_q == IDLE) && enc_found;
   assign complete = (state_q == BUSY) && mem_resp;
   assign ptr_next = (grant_idx_q == IW'(NUM_PORTS - 1)) ? '0 : grant_idx_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DONE is a mandatory dead cycle so a request the cache has not yet dropped is not re-granted.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enc_found) state_d = BUSY;
         BUSY:    if (mem_resp) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_valid = (state_q == BUSY);
      req_resp    = '0;
      if (state_q == BUSY && mem_resp) begin
         req_resp = NUM_PORTS'(1) << grant_idx_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_idx_q   <= '0;
         rr_ptr_q      <= '0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
      end else if (launch) begin
         grant_idx_q   <= enc_idx;
         // A simultaneous read and write latches as a write only.
         mem_write_q   <= sel_write;
         mem_read_q    <= sel_read & ~sel_write;
         mem_address_q <= sel_addr;
         mem_wdata_q   <= sel_wdata;
      end else if (complete) begin
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         if (ARB_MODE == ARB_RR) begin
            rr_ptr_q <= ptr_next;
         end
      end
   end

   assign grant_idx   = grant_idx_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_address = mem_address_q;
   assign mem_wdata   = mem_wdata_q;
   assign req_rdata   = mem_rdata;

   a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
   a_resp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_resp));

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench: a transaction-level arbiter model predicts grants, a negedge monitor checks them.
module tb_mem_arbiter_rr;
   import rv32i_types::*;

   localparam int unsigned NP = 4;
   localparam int unsigned LW = 64;
   localparam int unsigned AW = 32;
   localparam int unsigned IW = 2;
   localparam int unsigned FP = 3;

   localparam int PH_OFF    = 0;
   localparam int PH_DIRECT = 1;
   localparam int PH_RAND   = 2;
   localparam int PH_HOLD   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NP-1:0]    req_read, req_write, req_resp;
   logic [NP*AW-1:0] req_address;
   logic [NP*LW-1:0] req_wdata;
   logic [LW-1:0]    req_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0]    mem_address;
   logic             mem_read, mem_write, mem_resp, grant_valid;
   logic [IW-1:0]    grant_idx;

   logic [FP-1:0]    fx_req_read, fx_req_write, fx_req_resp;
   logic [FP*AW-1:0] fx_req_address;
   logic [FP*LW-1:0] fx_req_wdata;
   logic [LW-1:0]    fx_req_rdata, fx_mem_wdata, fx_mem_rdata;
   logic [AW-1:0]    fx_mem_address;
   logic             fx_mem_read, fx_mem_write, fx_mem_resp, fx_grant_valid;
   logic [1:0]       fx_grant_idx;

   mem_arbiter_rr #(
      .NUM_PORTS(NP), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .ARB_MODE(ARB_RR)
   ) dut (
      .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
      .req_address(req_address), .req_wdata(req_wdata), .req_rdata(req_rdata),
      .req_resp(req_resp), .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
      .mem_resp(mem_resp), .grant_valid(grant_valid), .grant_idx(grant_idx)
   );

   mem_arbiter_rr #(
      .NUM_PORTS(FP), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .ARB_MODE(ARB_FIXED)
   ) dut_fx (
      .clk(clk), .rst(rst), .req_read(fx_req_read), .req_write(fx_req_write),
      .req_address(fx_req_address), .req_wdata(fx_req_wdata), .req_rdata(fx_req_rdata),
      .req_resp(fx_req_resp), .mem_address(fx_mem_address), .mem_wdata(fx_mem_wdata),
      .mem_read(fx_mem_read), .mem_write(fx_mem_write), .mem_rdata(fx_mem_rdata),
      .mem_resp(fx_mem_resp), .grant_valid(fx_grant_valid), .grant_idx(fx_grant_idx)
   );

   typedef struct {
      int            cyc;
      int unsigned   idx;
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wd;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   grant_log[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
   endtask

   // Requester state
   int            phase = PH_OFF;
   bit            act[NP];
   bit            p_rd[NP];
   bit            p_wr[NP];
   logic [AW-1:0] p_addr[NP];
   logic [LW-1:0] p_wd[NP];
   int            idle_cnt[NP];
   bit            stale[NP];
   bit            stale_want[NP];
   bit            resp_seen[NP];

   // L2 responder state
   bit            l2_stall = 1'b0;
   bit            l2_wait  = 1'b0;
   int            l2_cnt   = 0;
   int            l2_lat   = -1;
   bit            l2_force = 1'b0;
   logic [LW-1:0] l2_fdata = '0;

   function automatic logic [LW-1:0] rand_line();
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      return {a, b};
   endfunction

   task automatic new_payload(input int i);
      logic [31:0] r;
      r       = $urandom;
      p_rd[i] = 1'($urandom_range(0, 1));
      p_wr[i] = 1'($urandom_range(0, 1));
      if (!p_rd[i] && !p_wr[i]) p_rd[i] = 1'b1;
      p_addr[i] = {r[31:6], 6'b0};
      p_wd[i]   = rand_line();
   endtask

   task automatic set_port(input int i, input bit rd, input bit wr, input logic [AW-1:0] addr,
                           input logic [LW-1:0] wd, input bit hold_stale);
      act[i]        = 1'b1;
      p_rd[i]       = rd;
      p_wr[i]       = wr;
      p_addr[i]     = addr;
      p_wd[i]       = wd;
      stale_want[i] = hold_stale;
   endtask

   task automatic apply_ports();
      for (int i = 0; i < NP; i++) begin
         req_read[i]               = act[i] & p_rd[i];
         req_write[i]              = act[i] & p_wr[i];
         req_address[i*AW +: AW]   = p_addr[i];
         req_wdata[i*LW +: LW]     = p_wd[i];
      end
   endtask

   task automatic drive_l2();
      if (l2_stall) return;
      if (mem_resp) begin
         mem_resp = 1'b0;
      end else if (mem_read || mem_write) begin
         if (!l2_wait) begin
            l2_wait = 1'b1;
            l2_cnt  = (l2_lat >= 0) ? l2_lat : int'($urandom_range(0, 3));
         end
         if (l2_cnt == 0) begin
            mem_resp  = 1'b1;
            l2_wait   = 1'b0;
            mem_rdata = l2_force ? l2_fdata : rand_line();
         end else begin
            l2_cnt--;
         end
      end
   endtask

   task automatic drive_ports();
      for (int i = 0; i < NP; i++) begin
         if (resp_seen[i]) begin
            resp_seen[i] = 1'b0;
            if (phase == PH_HOLD) new_payload(i);
            else if (stale_want[i]) stale[i] = 1'b1;
            else begin
               act[i]      = 1'b0;
               idle_cnt[i] = int'($urandom_range(0, 4));
            end
         end else if (stale[i]) begin
            stale[i]    = 1'b0;
            act[i]      = 1'b0;
            idle_cnt[i] = int'($urandom_range(0, 4));
         end else if (phase == PH_RAND && !act[i]) begin
            if (idle_cnt[i] == 0) begin
               new_payload(i);
               act[i]        = 1'b1;
               stale_want[i] = 1'($urandom_range(0, 1));
            end else begin
               idle_cnt[i]--;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive_l2();
      drive_ports();
      apply_ports();
   endtask

   task automatic clear_ports();
      for (int i = 0; i < NP; i++) begin
         act[i]        = 1'b0;
         stale[i]      = 1'b0;
         stale_want[i] = 1'b0;
         resp_seen[i]  = 1'b0;
         idle_cnt[i]   = 0;
      end
      apply_ports();
   endtask

   // Reference model: one transaction at a time, one dead cycle after each completion,
   // winner is the first requester at or after the pointer (pointer = last winner + 1).
   int          cyc    = 0;
   bit          m_busy = 1'b0;
   bit          m_cool = 1'b0;
   bit          m_found;
   int unsigned m_ptr  = 0;
   int unsigned m_idx  = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
         m_cool = 1'b0;
         m_ptr  = 0;
         exp_q.delete();
      end else begin
         cyc++;
         if (m_busy) begin
            if (mem_resp) begin
               m_busy = 1'b0;
               m_cool = 1'b1;
               m_ptr  = (m_idx + 1) % NP;
            end
         end else if (m_cool) begin
            m_cool = 1'b0;
         end else begin
            m_found = 1'b0;
            for (int unsigned k = 0; k < NP; k++) begin
               if (!m_found && (req_read[(m_ptr + k) % NP] || req_write[(m_ptr + k) % NP])) begin
                  m_found = 1'b1;
                  m_idx   = (m_ptr + k) % NP;
               end
            end
            if (m_found) begin
               exp_q.push_back('{cyc: cyc, idx: m_idx,
                                 rd: req_read[m_idx] && !req_write[m_idx],
                                 wr: req_write[m_idx],
                                 addr: req_address[m_idx*AW +: AW],
                                 wd: req_wdata[m_idx*LW +: LW]});
               m_busy = 1'b1;
            end
         end
      end
   end

   // Monitor
   bit prev_gv  = 1'b0;
   bit cur_v    = 1'b0;
   int resp_cnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         cur_v    = 1'b0;
         prev_gv  = 1'b0;
         resp_cnt = 0;
      end else begin
         if (grant_valid && !prev_gv) begin
            grant_log.push_back(int'(grant_idx));
            chk("grant_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               cur      = exp_q.pop_front();
               cur_v    = 1'b1;
               resp_cnt = 0;
               chk("grant_cycle", 64'(cyc), 64'(cur.cyc));
               chk("grant_idx", 64'(grant_idx), 64'(cur.idx));
               chk("grant_strobes", 64'({mem_read, mem_write}), 64'({cur.rd, cur.wr}));
               chk("grant_addr", 64'(mem_address), 64'(cur.addr));
               chk("grant_wdata", mem_wdata, cur.wd);
            end
         end else if (grant_valid && cur_v) begin
            chk("hold_strobes", 64'({mem_read, mem_write}), 64'({cur.rd, cur.wr}));
            chk("hold_addr", 64'(mem_address), 64'(cur.addr));
            chk("hold_wdata", mem_wdata, cur.wd);
         end
         if (!grant_valid && prev_gv && cur_v) begin
            chk("resp_pulses", 64'(resp_cnt), 64'(1));
            cur_v = 1'b0;
         end
         if (!grant_valid) chk("idle_strobes", 64'({mem_read, mem_write}), 64'(0));
         if (req_resp != '0) begin
            resp_cnt++;
            for (int i = 0; i < NP; i++) if (req_resp[i]) resp_seen[i] = 1'b1;
            chk("resp_rdata", req_rdata, mem_rdata);
         end
         if (grant_valid && mem_resp && cur_v) chk("resp_port", 64'(req_resp), 64'(1) << cur.idx);
         else chk("resp_quiet", 64'(req_resp), 64'(0));
         prev_gv = grant_valid;
      end
   end

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int got[$];
   int cnt[NP];
   int r0;
   bit fx_prev;

   initial begin
      req_read = '0; req_write = '0; req_address = '0; req_wdata = '0;
      mem_rdata = '0; mem_resp = 1'b0;
      fx_req_read = '0; fx_req_write = '0; fx_req_address = '0; fx_req_wdata = '0;
      fx_mem_rdata = '0; fx_mem_resp = 1'b0;
      clear_ports();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant_valid", 64'(grant_valid), 64'(0));
      chk("rst_grant_idx", 64'(grant_idx), 64'(0));
      chk("rst_strobes", 64'({mem_read, mem_write}), 64'(0));
      chk("rst_addr", 64'(mem_address), 64'(0));
      chk("rst_wdata", mem_wdata, 64'(0));
      chk("rst_resp", 64'(req_resp), 64'(0));
      rst = 1'b0;

      // Single read with 4-cycle L2 latency; requester holds its read one cycle past req_resp
      phase    = PH_DIRECT;
      l2_lat   = 4;
      l2_force = 1'b1;
      l2_fdata = {8{8'hA5}};
      set_port(0, 1'b1, 1'b0, 32'h0000_0100, '0, 1'b1);
      apply_ports();
      step();
      chk("rd_mem_read", 64'({mem_read, mem_write}), 64'(2'b10));
      chk("rd_mem_addr", 64'(mem_address), 64'h100);
      for (int k = 0; k < 20 && act[0]; k++) step();
      chk("rd_completed", 64'(act[0]), 64'(0));
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stale_no_regrant", 64'(mem_read), 64'(0));
      end
      l2_lat   = -1;
      l2_force = 1'b0;

      // Read/write collision on port 1
      set_port(1, 1'b1, 1'b1, 32'h0000_0200, {2{32'hDEAD_BEEF}}, 1'b0);
      apply_ports();
      step();
      chk("coll_strobes", 64'({mem_read, mem_write}), 64'(2'b01));
      chk("coll_wdata", mem_wdata, {2{32'hDEAD_BEEF}});
      chk("coll_idx", 64'(grant_idx), 64'(1));
      for (int k = 0; k < 20 && act[1]; k++) step();

      // Randomised traffic against the model
      phase = PH_RAND;
      repeat (1500) step();
      phase = PH_OFF;
      clear_ports();
      repeat (20) step();
      chk("drain_rand", 64'(exp_q.size()), 64'(0));

      // Asynchronous reset in the middle of a transaction
      phase = PH_DIRECT;
      l2_stall = 1'b1;
      set_port(2, 1'b1, 1'b0, 32'h0000_0080, '0, 1'b0);
      apply_ports();
      for (int k = 0; k < 10 && !grant_valid; k++) step();
      chk("rstmid_busy", 64'(grant_valid), 64'(1));
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid_grant_valid", 64'(grant_valid), 64'(0));
      chk("rstmid_strobes", 64'({mem_read, mem_write}), 64'(0));
      chk("rstmid_addr", 64'(mem_address), 64'(0));
      chk("rstmid_grant_idx", 64'(grant_idx), 64'(0));
      chk("rstmid_resp", 64'(req_resp), 64'(0));
      clear_ports();
      l2_stall = 1'b0;
      l2_wait  = 1'b0;
      mem_resp = 1'b0;
      step();
      step();
      rst = 1'b0;
      set_port(1, 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0);
      apply_ports();
      step();
      chk("post_rst_read", 64'(mem_read), 64'(1));
      chk("post_rst_addr", 64'(mem_address), 64'h40);
      chk("post_rst_idx", 64'(grant_idx), 64'(1));
      for (int k = 0; k < 20 && act[1]; k++) step();
      repeat (4) step();

      // Round-robin fairness from reset, all four ports requesting continuously
      rst = 1'b1;
      clear_ports();
      step();
      rst = 1'b0;
      grant_log.delete();
      phase = PH_HOLD;
      for (int i = 0; i < NP; i++) begin
         new_payload(i);
         act[i] = 1'b1;
      end
      apply_ports();
      for (int k = 0; k < 200 && grant_log.size() < 8; k++) step();
      phase = PH_OFF;
      clear_ports();
      chk("rr_count", 64'(grant_log.size()), 64'(8));
      for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_order", 64'(grant_log[i]), 64'(i % 4));
      for (int p = 0; p < NP; p++) cnt[p] = 0;
      foreach (grant_log[i]) if (grant_log[i] >= 0 && grant_log[i] < NP) cnt[grant_log[i]]++;
      for (int p = 0; p < NP; p++) chk("rr_share", 64'(cnt[p]), 64'(2));
      repeat (20) step();
      chk("drain_rr", 64'(exp_q.size()), 64'(0));

      // Fixed priority, 3 ports: port 0 wins until it drops, then port 2
      fx_req_read = 3'b101;
      fx_prev     = 1'b0;
      r0          = 0;
      for (int c = 0; c < 200 && got.size() < 4; c++) begin
         @(negedge clk);
         fx_mem_resp = fx_mem_read | fx_mem_write;
         #1;
         if (fx_grant_valid && !fx_prev) got.push_back(int'(fx_grant_idx));
         fx_prev = fx_grant_valid;
         if (fx_req_resp[0]) begin
            r0++;
            if (r0 == 3) fx_req_read[0] = 1'b0;
         end
      end
      fx_req_read = '0;
      repeat (10) begin
         @(negedge clk);
         fx_mem_resp = fx_mem_read | fx_mem_write;
      end
      chk("fx_count", 64'(got.size()), 64'(4));
      for (int i = 0; i < 4 && i < got.size(); i++) chk("fx_order", 64'(got[i]), (i < 3) ? 64'(0) : 64'(2));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
